// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage CPU: write-enable/flush pairs for every
// pipeline register, PC enable, MDU busy tracking and stall/flush event counters.
module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        mem_ready,
  input  logic        ex_branch_taken,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        ex_mdu_start,
  input  logic        id_mdu_access,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_we,
  output logic        idex_flush,
  output logic        exmem_we,
  output logic        exmem_flush,
  output logic        memwb_we,
  output logic        memwb_flush,
  output logic        mdu_busy,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lu, mh;
  logic              redirect;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The MDU counts down through freezes: its occupancy is wall-clock, not pipeline progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (ex_mdu_start && mem_ready) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign mdu_busy = (state_q == BUSY);

  assign lu = ex_mem_read && (ex_rt != 5'd0) &&
              ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));
  assign mh = mdu_busy && id_mdu_access;

  // Handshake: mem_ready is a ready with no matching valid; while it is low no
  // pipeline register may capture or flush, so every control drops to 0.
  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_we     = 1'b0;
    idex_flush  = 1'b0;
    exmem_we    = 1'b0;
    exmem_flush = 1'b0;
    memwb_we    = 1'b0;
    memwb_flush = 1'b0;
    redirect    = 1'b0;
    if (Rst || !mem_ready) begin
      pc_we = 1'b0;
    end else if (ex_branch_taken) begin
      // The ID instruction is wrong-path, so its hazards are irrelevant.
      redirect   = 1'b1;
      pc_we      = 1'b1;
      ifid_we    = 1'b1;
      ifid_flush = 1'b1;
      idex_we    = 1'b1;
      idex_flush = 1'b1;
      exmem_we   = 1'b1;
      memwb_we   = 1'b1;
    end else if (lu || mh) begin
      idex_we    = 1'b1;
      idex_flush = 1'b1;
      exmem_we   = 1'b1;
      memwb_we   = 1'b1;
    end else begin
      pc_we    = 1'b1;
      ifid_we  = 1'b1;
      idex_we  = 1'b1;
      exmem_we = 1'b1;
      memwb_we = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_we && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (redirect && (flush_events != 32'hFFFF_FFFF))
        flush_events <= flush_events + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios then random traffic,
// compared against a cycle-level reference model through an expected queue.
module tb_pipe_hazard_ctrl;

  localparam int MDU_LAT = 4;
  localparam int W = 74;

  logic        clk;
  logic        rst;
  logic        mem_ready, ex_branch_taken, ex_mem_read;
  logic [4:0]  ex_rt, id_rs, id_rt;
  logic        id_use_rs, id_use_rt, ex_mdu_start, id_mdu_access;
  logic        pc_we, ifid_we, ifid_flush, idex_we, idex_flush;
  logic        exmem_we, exmem_flush, memwb_we, memwb_flush;
  logic        mdu_busy;
  logic [31:0] stall_cycles, flush_events;

  logic [W-1:0] exp_q[$];
  int           n_vec;
  int           n_err;

  // model state
  int           busy_left;
  longint       m_stall, m_flush;

  pipe_hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(6)) dut (
    .clk(clk), .Rst(rst), .mem_ready(mem_ready), .ex_branch_taken(ex_branch_taken),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_mdu_start(ex_mdu_start),
    .id_mdu_access(id_mdu_access), .pc_we(pc_we), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idex_we(idex_we), .idex_flush(idex_flush),
    .exmem_we(exmem_we), .exmem_flush(exmem_flush), .memwb_we(memwb_we),
    .memwb_flush(memwb_flush), .mdu_busy(mdu_busy), .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic idle_inputs();
    mem_ready       = 1'b1;
    ex_branch_taken = 1'b0;
    ex_mem_read     = 1'b0;
    ex_rt           = 5'd0;
    id_rs           = 5'd0;
    id_rt           = 5'd0;
    id_use_rs       = 1'b0;
    id_use_rt       = 1'b0;
    ex_mdu_start    = 1'b0;
    id_mdu_access   = 1'b0;
  endtask

  task automatic rand_inputs();
    mem_ready       = ($urandom_range(0, 9) < 8);
    ex_branch_taken = ($urandom_range(0, 6) == 0);
    ex_mem_read     = $urandom_range(0, 1);
    ex_rt           = 5'($urandom_range(0, 3));
    id_rs           = 5'($urandom_range(0, 3));
    id_rt           = 5'($urandom_range(0, 3));
    id_use_rs       = $urandom_range(0, 1);
    id_use_rt       = $urandom_range(0, 1);
    ex_mdu_start    = ($urandom_range(0, 9) == 0);
    id_mdu_access   = ($urandom_range(0, 2) == 0);
  endtask

  // Present current inputs for one cycle: predict, queue, advance the model.
  task automatic apply();
    logic       lu, mh, redirect, busy;
    logic [8:0] ctl;
    if (rst) begin
      busy_left = 0;
      m_stall   = 0;
      m_flush   = 0;
    end
    lu = ex_mem_read && (ex_rt != 0) &&
         ((id_use_rs && id_rs == ex_rt) || (id_use_rt && id_rt == ex_rt));
    busy = (busy_left > 0);
    mh = busy && id_mdu_access;
    redirect = 1'b0;
    // order: pc, ifid we/fl, idex we/fl, exmem we/fl, memwb we/fl
    if (rst || !mem_ready)      ctl = 9'b000000000;
    else if (ex_branch_taken) begin
      ctl = 9'b111111010;
      redirect = 1'b1;
    end
    else if (lu || mh)          ctl = 9'b000111010;
    else                        ctl = 9'b110101010;
    exp_q.push_back({ctl, busy, m_stall[31:0], m_flush[31:0]});
    @(posedge clk);
    if (!rst) begin
      if (!ctl[8])  m_stall = (m_stall >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_stall + 1;
      if (redirect) m_flush = (m_flush >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_flush + 1;
      if (busy_left > 0) busy_left--;
      else if (ex_mdu_start && mem_ready) busy_left = MDU_LAT;
    end
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] exp, act;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush,
             memwb_we, memwb_flush, mdu_busy, stall_cycles, flush_events};
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL vec %0d @%0t ctl act=%b exp=%b busy act=%b exp=%b stall act=%0d exp=%0d flush act=%0d exp=%0d",
                 n_vec, $time, act[73:65], exp[73:65], act[64], exp[64],
                 act[63:32], exp[63:32], act[31:0], exp[31:0]);
      end
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    busy_left = 0;
    m_stall = 0;
    m_flush = 0;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;

    // reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      apply();
    end
    rst = 1'b0;
    idle_inputs();
    apply();

    // load-use, then the same with ex_rt = 0
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_use_rs = 1'b1; id_rs = 5'd5;
    apply();
    idle_inputs();
    apply();
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_use_rs = 1'b1; id_rs = 5'd0;
    apply();
    ex_mem_read = 1'b1; ex_rt = 5'd7; id_use_rt = 1'b1; id_rt = 5'd7; id_rs = 5'd7;
    apply();

    // branch plus load-use
    idle_inputs();
    ex_branch_taken = 1'b1;
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_use_rs = 1'b1; id_rs = 5'd5;
    apply();
    idle_inputs();
    apply();

    // MDU busy window with ID hammering the MDU
    ex_mdu_start = 1'b1;
    apply();
    ex_mdu_start = 1'b0;
    id_mdu_access = 1'b1;
    for (int i = 0; i < MDU_LAT + 2; i++) apply();

    // freeze while busy, with a branch inside the freeze
    idle_inputs();
    ex_mdu_start = 1'b1;
    apply();
    ex_mdu_start = 1'b0;
    id_mdu_access = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0;
      ex_branch_taken = (i == 1);
      apply();
    end
    mem_ready = 1'b1;
    ex_branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) apply();

    // reset two cycles into an MDU operation
    idle_inputs();
    ex_mdu_start = 1'b1;
    apply();
    ex_mdu_start = 1'b0;
    id_mdu_access = 1'b1;
    apply();
    apply();
    rst = 1'b1;
    apply();
    apply();
    rst = 1'b0;
    apply();
    apply();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      rand_inputs();
      apply();
    end
    rst = 1'b0;
    idle_inputs();
    apply();

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: pending act=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control block for the 5-stage CPU. It generates the write-enable and flush pairs that drive the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC enable. It handles memory wait stalls, EX-stage branch redirect flushes, load-use interlocks, and the busy window of the iterative multiply/divide unit (MDU). It sits directly upstream of every pipeline register's `write_enable`/`flush` inputs. A register flushes only when both its `_we` and its `_flush` are high.

## Interface
Parameters:
- `MDU_LAT`, default 32: MDU occupancy in cycles per operation (≥2).
- `CNT_W`, default 6: MDU down-counter width; must hold `MDU_LAT-1`.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `mem_ready` in 1: data memory ready. 0 freezes the whole pipeline.
- `ex_branch_taken` in 1: branch/jump in EX resolved taken this cycle.
- `ex_mem_read` in 1: EX instruction is a load.
- `ex_rt` in 5: load destination register in EX.
- `id_rs`, `id_rt` in 5 each: source registers of the ID instruction.
- `id_use_rs`, `id_use_rt` in 1 each: the ID instruction actually reads rs / rt.
- `ex_mdu_start` in 1: EX instruction is mult/multu/div/divu.
- `id_mdu_access` in 1: ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
- `pc_we` out 1: PC write enable.
- `ifid_we`, `ifid_flush`, `idex_we`, `idex_flush`, `exmem_we`, `exmem_flush`, `memwb_we`, `memwb_flush` out 1 each: pipeline register controls.
- `mdu_busy` out 1: registered; MDU operation in progress.
- `stall_cycles` out 32: saturating count of cycles with `pc_we`=0 (Rst excluded).
- `flush_events` out 32: saturating count of branch-flush cycles.

## Operation
- State machine: `IDLE`, `BUSY`. `mdu_busy` = (state==`BUSY`).
  - `IDLE`→`BUSY` when `ex_mdu_start` && `mem_ready` && !`Rst`. The down-counter is loaded with `MDU_LAT-1`.
  - In `BUSY`, the counter decrements every cycle, including cycles with `mem_ready`=0.
  - `BUSY`→`IDLE` on the edge where the counter equals 0.
  - `ex_mdu_start` while `BUSY` is ignored. The interlock below prevents it.
- Hazard terms:
  - `lu` = `ex_mem_read` && `ex_rt`≠0 && ((`id_use_rs` && `id_rs`==`ex_rt`) || (`id_use_rt` && `id_rt`==`ex_rt`)).
  - `mh` = `mdu_busy` && `id_mdu_access`.
- Control outputs are combinational from inputs and state. Apply the first matching rule:
  1. `Rst`=1: all `_we`/`_flush` = 0.
  2. `mem_ready`=0 (freeze): all `_we` = 0, all `_flush` = 0.
  3. `ex_branch_taken` (redirect): `pc_we`=1; `ifid_we`=`ifid_flush`=1; `idex_we`=`idex_flush`=1; `exmem_we`=`memwb_we`=1; the other flushes are 0. Any `lu`/`mh` is discarded because the ID instruction is wrong-path.
  4. `lu` || `mh` (interlock): `pc_we`=0, `ifid_we`=0; `idex_we`=`idex_flush`=1 (bubble); `exmem_we`=`memwb_we`=1.
  5. Otherwise (run): all `_we`=1, all `_flush`=0.
- `exmem_flush` and `memwb_flush` are always 0. They are provided for interface symmetry.
- Counters:
  - `stall_cycles` increments on each edge where `pc_we`=0 and `Rst`=0.
  - `flush_events` increments on each edge where rule 3 is active.
  - Both hold at 32'hFFFF_FFFF.

## Timing
- Reset values: state `IDLE`, counter 0, `mdu_busy`=0, `stall_cycles`=0, `flush_events`=0, all control outputs 0.
- `Rst` asserted mid-MDU operation clears `BUSY` immediately (asynchronous). After release the block starts in `IDLE`.
- Control outputs have zero latency: they are valid in the same cycle their inputs are.
- `mdu_busy` rises on the edge after the accepted start. It stays high for exactly `MDU_LAT` cycles, including across freezes.
- A load-use interlock lasts exactly 1 cycle. On the next cycle the load has moved to MEM and `lu` drops.
- A branch and a freeze in the same cycle: the freeze wins. The branch is re-presented on the next cycle with `mem_ready`=1 and is serviced then.
- `ex_rt`=0 never causes an interlock.

## Test plan
- Reset: hold `Rst` 3 cycles with random inputs → all `_we`/`_flush`=0, `mdu_busy`=0, both counters 0.
- Load-use: `ex_mem_read`=1, `ex_rt`=5, `id_use_rs`=1, `id_rs`=5 for 1 cycle → `pc_we`=0, `ifid_we`=0, `idex_we`=`idex_flush`=1, `stall_cycles`=1. Repeat with `ex_rt`=0 → run outputs.
- Branch plus hazard: `ex_branch_taken`=1 with the same load-use inputs → `pc_we`=1, IF/ID and ID/EX flushed, `flush_events`=1, `stall_cycles` unchanged.
- MDU: `MDU_LAT`=4, pulse `ex_mdu_start` → `mdu_busy` high for 4 cycles. `id_mdu_access`=1 throughout → 4 interlock cycles, then run on the 5th.
- Freeze: `mem_ready`=0 for 3 cycles while `BUSY` → all `_we`=0. `mdu_busy` still falls after `MDU_LAT` total cycles. A branch during the freeze is not counted.
- Reset mid-op: assert `Rst` 2 cycles after an MDU start → `mdu_busy`=0 asynchronously. After release, `id_mdu_access`=1 gives run outputs.
